// File: rtl/snitch_amo_shim_mres.sv
// Atomic-memory shim for one TCDM bank: pass-through accesses, 32/64-bit AMOs
// and per-core LR/SC reservations, with DMA bypass priority.

package reqrsp_pkg;
  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;
endpackage

// state     | meaning
// Idle      | pass-through, accept new requests
// DoAMO     | old word on mem_rdata_i, compute and register result
// WriteBack | write result, wait while the DMA owns the port
module snitch_amo_shim_mres #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumCores     = 8,
  parameter int unsigned CoreIDWidth  = $clog2(NumCores),
  parameter int unsigned StrbWidth    = DataWidth/8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    dma_access_i,
  input  logic [AddrMemWidth-1:0] addr_i,
  input  reqrsp_pkg::amo_op_e     amo_i,
  input  logic                    amo_d_i,
  input  logic                    write_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [StrbWidth-1:0]    wstrb_i,
  output logic [DataWidth-1:0]    rdata_o,
  input  logic [CoreIDWidth-1:0]  core_id_i,
  input  logic                    is_core_i,
  output logic                    mem_req_o,
  output logic [AddrMemWidth-1:0] mem_add_o,
  output logic                    mem_wen_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [StrbWidth-1:0]    mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  output logic [NumCores-1:0]     rsv_valid_o,
  output logic                    amo_conflict_o
);
  import reqrsp_pkg::*;

  typedef enum logic [1:0] {Idle, DoAMO, WriteBack} state_e;

  state_e                                 state_q, state_d;
  amo_op_e                                op_q, op_d;
  logic [AddrMemWidth-1:0]                addr_q, addr_d;
  logic                                   idx_q, idx_d;
  logic                                   dsize_q, dsize_d;
  logic [63:0]                            opb_q, opb_d;
  logic [63:0]                            result_q, result_d;
  logic                                   sc_fwd_q, sc_fwd_d;
  logic                                   sc_fail_q, sc_fail_d;
  logic                                   sc_dsize_q, sc_dsize_d;
  logic [NumCores-1:0]                    rsv_valid_q, rsv_valid_d;
  logic [NumCores-1:0][AddrMemWidth-1:0]  rsv_addr_q, rsv_addr_d;
  logic [NumCores-1:0]                    rsv_dsize_q, rsv_dsize_d;

  logic [63:0] wdata64, rdata64, alu_res, wb_data, sc_rdata;
  logic [7:0]  wb_be;
  logic        lane_sel, is_rmw, core_req, sc_ok, kill_en;
  logic [63:0] alu_a;
  logic [64:0] a_ext, b_ext;
  logic        is_signed, a_lt_b;

  assign wdata64 = 64'(wdata_i);
  assign rdata64 = 64'(mem_rdata_i);

  if (DataWidth == 64) begin : g_lane64
    assign lane_sel = wstrb_i[4];
  end else begin : g_lane32
    assign lane_sel = 1'b0;
  end

  assign is_rmw   = (amo_i != AMONone) && (amo_i != AMOLR) && (amo_i != AMOSC);
  assign core_req = valid_i && !dma_access_i && (state_q == Idle);
  assign sc_ok    = is_core_i && rsv_valid_q[core_id_i] &&
                    (rsv_addr_q[core_id_i] == addr_i) &&
                    (rsv_dsize_q[core_id_i] == amo_d_i);

  // Word ops use the selected 32-bit lane, sign- or zero-extended for compares
  always_comb begin
    alu_a     = dsize_q ? rdata64 :
                (idx_q ? {32'b0, rdata64[63:32]} : {32'b0, rdata64[31:0]});
    is_signed = (op_q == AMOMax) || (op_q == AMOMin);
    if (dsize_q) begin
      a_ext = {is_signed & alu_a[63], alu_a};
      b_ext = {is_signed & opb_q[63], opb_q};
    end else begin
      a_ext = {{33{is_signed & alu_a[31]}}, alu_a[31:0]};
      b_ext = {{33{is_signed & opb_q[31]}}, opb_q[31:0]};
    end
    a_lt_b = $signed(a_ext) < $signed(b_ext);
    unique case (op_q)
      AMOSwap:         alu_res = opb_q;
      AMOAdd:          alu_res = alu_a + opb_q;
      AMOAnd:          alu_res = alu_a & opb_q;
      AMOOr:           alu_res = alu_a | opb_q;
      AMOXor:          alu_res = alu_a ^ opb_q;
      AMOMax, AMOMaxu: alu_res = a_lt_b ? opb_q : alu_a;
      AMOMin, AMOMinu: alu_res = a_lt_b ? alu_a : opb_q;
      default:         alu_res = alu_a;
    endcase
  end

  assign wb_data  = dsize_q ? result_q :
                    (idx_q ? {result_q[31:0], 32'b0} : {32'b0, result_q[31:0]});
  assign wb_be    = dsize_q ? 8'hFF : (idx_q ? 8'hF0 : 8'h0F);
  assign sc_rdata = sc_dsize_q ? {63'b0, sc_fail_q} : {31'b0, sc_fail_q, 31'b0, sc_fail_q};

  assign rdata_o        = sc_fwd_q ? sc_rdata[DataWidth-1:0] : mem_rdata_i;
  assign rsv_valid_o    = rsv_valid_q;
  assign amo_conflict_o = dma_access_i && (state_q != Idle) && (addr_q == addr_i);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    dsize_d     = dsize_q;
    opb_d       = opb_q;
    result_d    = result_q;
    sc_fwd_d    = 1'b0;
    sc_fail_d   = sc_fail_q;
    sc_dsize_d  = sc_dsize_q;
    mem_req_o   = valid_i;
    mem_add_o   = addr_i;
    mem_wen_o   = write_i;
    mem_wdata_o = wdata_i;
    mem_be_o    = wstrb_i;
    ready_o     = 1'b1;
    unique case (state_q)
      Idle: begin
        if (core_req) begin
          if (is_rmw) begin
            mem_wen_o = 1'b0;
            op_d      = amo_i;
            addr_d    = addr_i;
            idx_d     = lane_sel;
            dsize_d   = amo_d_i;
            opb_d     = amo_d_i ? wdata64 :
                        (lane_sel ? {32'b0, wdata64[63:32]} : {32'b0, wdata64[31:0]});
            state_d   = DoAMO;
          end else if (amo_i == AMOLR) begin
            mem_wen_o = 1'b0;
          end else if (amo_i == AMOSC) begin
            mem_wen_o  = sc_ok;
            sc_fwd_d   = 1'b1;
            sc_fail_d  = !sc_ok;
            sc_dsize_d = amo_d_i;
          end
        end
      end
      DoAMO: begin
        ready_o   = dma_access_i;
        mem_req_o = dma_access_i && valid_i;
        result_d  = alu_res;
        state_d   = WriteBack;
      end
      WriteBack: begin
        if (!dma_access_i) begin
          ready_o     = 1'b0;
          mem_req_o   = 1'b1;
          mem_wen_o   = 1'b1;
          mem_add_o   = addr_q;
          mem_wdata_o = wb_data[DataWidth-1:0];
          mem_be_o    = wb_be[StrbWidth-1:0];
          state_d     = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Kill first, then the requester's own LR/SC update, so LR wins over its own kill
  always_comb begin
    rsv_valid_d = rsv_valid_q;
    rsv_addr_d  = rsv_addr_q;
    rsv_dsize_d = rsv_dsize_q;
    kill_en     = valid_i && ((dma_access_i && write_i) ||
                  (core_req && (write_i || is_rmw || ((amo_i == AMOSC) && sc_ok))));
    for (int s = 0; s < NumCores; s++) begin
      if (kill_en && rsv_valid_q[s] && (rsv_addr_q[s] == addr_i) &&
          !(is_core_i && !dma_access_i && (CoreIDWidth'(s) == core_id_i)))
        rsv_valid_d[s] = 1'b0;
    end
    if (core_req && is_core_i && (amo_i == AMOLR)) begin
      rsv_valid_d[core_id_i] = 1'b1;
      rsv_addr_d[core_id_i]  = addr_i;
      rsv_dsize_d[core_id_i] = amo_d_i;
    end else if (core_req && is_core_i && (amo_i == AMOSC)) begin
      rsv_valid_d[core_id_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      op_q        <= AMONone;
      addr_q      <= '0;
      idx_q       <= 1'b0;
      dsize_q     <= 1'b0;
      opb_q       <= '0;
      result_q    <= '0;
      sc_fwd_q    <= 1'b0;
      sc_fail_q   <= 1'b0;
      sc_dsize_q  <= 1'b0;
      rsv_valid_q <= '0;
      rsv_addr_q  <= '0;
      rsv_dsize_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      dsize_q     <= dsize_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      sc_fwd_q    <= sc_fwd_d;
      sc_fail_q   <= sc_fail_d;
      sc_dsize_q  <= sc_dsize_d;
      rsv_valid_q <= rsv_valid_d;
      rsv_addr_q  <= rsv_addr_d;
      rsv_dsize_q <= rsv_dsize_d;
    end
  end

endmodule

// File: tb/tb_snitch_amo_shim_mres.sv
// Directed bench for snitch_amo_shim_mres with a behavioural one-cycle SRAM.
module tb_snitch_amo_shim_mres;
  import reqrsp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready, dma, amo_d, write, is_core;
  logic [31:0] addr;
  amo_op_e     amo;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [2:0]  core_id;
  logic        mem_req, mem_wen, conflict;
  logic [31:0] mem_add;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be, rsv_valid;

  logic [63:0] mem [256];
  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  snitch_amo_shim_mres dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .dma_access_i(dma), .addr_i(addr), .amo_i(amo), .amo_d_i(amo_d),
    .write_i(write), .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rdata),
    .core_id_i(core_id), .is_core_i(is_core), .mem_req_o(mem_req),
    .mem_add_o(mem_add), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata), .rsv_valid_o(rsv_valid),
    .amo_conflict_o(conflict)
  );

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_wen) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) mem[mem_add[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_add[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid = 0; dma = 0; amo = AMONone; amo_d = 0; write = 0;
    wdata = '0; wstrb = '0; core_id = '0; is_core = 0; addr = '0;
  endtask

  task automatic drive(input amo_op_e op, input logic d, input logic [31:0] a,
                       input logic w, input logic [63:0] wd, input logic [7:0] st,
                       input logic [2:0] c, input logic ic);
    valid = 1; dma = 0; amo = op; amo_d = d; addr = a; write = w;
    wdata = wd; wstrb = st; core_id = c; is_core = ic;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    drive(AMONone, 0, a, 1, d, 8'hFF, 3'd0, 0);
    neg(); nxt(); idle();
  endtask

  task automatic do_amo(input string tag, input amo_op_e op, input logic d,
                        input logic [31:0] a, input logic [63:0] wd, input logic [7:0] st,
                        input logic [63:0] exp_old, input logic [63:0] exp_wd,
                        input logic [7:0] exp_be);
    drive(op, d, a, 0, wd, st, 3'd0, 1);
    neg();
    chk({tag, "_c0_ready"}, 64'(ready), 64'd1);
    chk({tag, "_c0_wen"}, 64'(mem_wen), 64'd0);
    nxt(); idle();
    neg();
    chk({tag, "_c1_old"}, rdata, exp_old);
    chk({tag, "_c1_ready"}, 64'(ready), 64'd0);
    chk({tag, "_c1_req"}, 64'(mem_req), 64'd0);
    nxt();
    neg();
    chk({tag, "_c2_wen"}, 64'({mem_req, mem_wen}), 64'd3);
    chk({tag, "_c2_addr"}, 64'(mem_add), 64'(a));
    chk({tag, "_c2_be"}, 64'(mem_be), 64'(exp_be));
    chk({tag, "_c2_data"}, mem_wdata, exp_wd);
    nxt();
    neg();
    chk({tag, "_c3_ready"}, 64'(ready), 64'd1);
    nxt();
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    drive(AMONone, 0, 32'h5, 1, 64'h1234, 8'hFF, 3'd0, 0);
    #2;
    chk("rst_req", 64'(mem_req), 64'd1);
    chk("rst_add", 64'(mem_add), 64'h5);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_rsv", 64'(rsv_valid), 64'd0);
    chk("rst_conflict", 64'(conflict), 64'd0);
    idle();
    #10 rst_n = 1;
    nxt();

    wr(32'h10, 64'h00000005_00000003);
    wr(32'h40, 64'hFFFFFFFF_00000000);
    wr(32'h30, 64'h5);
    wr(32'h50, 64'h11);

    drive(AMONone, 0, 32'h10, 0, 64'h0, 8'hFF, 3'd0, 0);
    neg(); chk("plain_rd_wen", 64'(mem_wen), 64'd0);
    nxt(); idle();
    neg(); chk("plain_rd_data", rdata, 64'h00000005_00000003);
    nxt();

    do_amo("add_w1", AMOAdd, 0, 32'h10, 64'h00000007_00000000, 8'hF0,
           64'h00000005_00000003, 64'h0000000C_00000000, 8'hF0);
    chk("add_w1_mem", mem[8'h10], 64'h0000000C_00000003);
    do_amo("max_w0", AMOMax, 0, 32'h10, 64'h00000000_FFFFFFFE, 8'h0F,
           64'h0000000C_00000003, 64'h00000000_00000003, 8'h0F);
    do_amo("maxu_d", AMOMaxu, 1, 32'h40, 64'h1, 8'hFF,
           64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 8'hFF);
    do_amo("min_d", AMOMin, 1, 32'h40, 64'h1, 8'hFF,
           64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 8'hFF);
    do_amo("minu_d", AMOMinu, 1, 32'h40, 64'h1, 8'hFF,
           64'hFFFFFFFF_00000000, 64'h1, 8'hFF);

    // Two harts with independent reservations
    drive(AMOLR, 0, 32'h20, 0, 64'h0, 8'h0F, 3'd0, 1);
    neg(); chk("lr0_wen", 64'(mem_wen), 64'd0);
    nxt();
    drive(AMOLR, 0, 32'h28, 0, 64'h0, 8'h0F, 3'd1, 1);
    neg(); nxt(); idle();
    neg(); chk("lr_rsv", 64'(rsv_valid), 64'h03);
    nxt();
    drive(AMOSC, 0, 32'h28, 0, 64'h99, 8'h0F, 3'd1, 1);
    neg(); chk("sc1_store", 64'({mem_req, mem_wen}), 64'd3);
    nxt(); idle();
    neg(); chk("sc1_res", rdata, 64'h0);
    nxt();
    drive(AMOSC, 0, 32'h20, 0, 64'h98, 8'h0F, 3'd0, 1);
    neg(); chk("sc0_store", 64'({mem_req, mem_wen}), 64'd3);
    nxt(); idle();
    neg(); chk("sc0_res", rdata, 64'h0);
    chk("sc_rsv_clr", 64'(rsv_valid), 64'h0);
    nxt();

    // Foreign store kills the reservation
    drive(AMOLR, 0, 32'h20, 0, 64'h0, 8'h0F, 3'd0, 1);
    neg(); nxt();
    drive(AMONone, 0, 32'h20, 1, 64'h77, 8'h0F, 3'd3, 1);
    neg(); nxt(); idle();
    neg(); chk("kill_rsv", 64'(rsv_valid), 64'h0);
    nxt();
    drive(AMOSC, 0, 32'h20, 0, 64'h55, 8'h0F, 3'd0, 1);
    neg(); chk("scf_req", 64'(mem_req), 64'd1);
    chk("scf_wen", 64'(mem_wen), 64'd0);
    nxt(); idle();
    neg(); chk("scf_res", rdata, 64'h00000001_00000001);
    nxt();

    // Own store keeps the requester's reservation
    drive(AMOLR, 1, 32'h60, 0, 64'h0, 8'hFF, 3'd2, 1);
    neg(); nxt();
    drive(AMONone, 0, 32'h60, 1, 64'h66, 8'hFF, 3'd2, 1);
    neg(); nxt(); idle();
    neg(); chk("own_rsv", 64'(rsv_valid), 64'h04);
    nxt();
    drive(AMOSC, 1, 32'h60, 0, 64'h67, 8'hFF, 3'd2, 1);
    neg(); chk("own_sc_wen", 64'(mem_wen), 64'd1);
    nxt(); idle();
    neg(); chk("own_sc_res", rdata, 64'h0);
    nxt();

    // DMA clash during write-back
    drive(AMOSwap, 1, 32'h30, 0, 64'hAB, 8'hFF, 3'd0, 1);
    neg(); nxt(); idle();
    neg(); chk("dma_old", rdata, 64'h5);
    nxt();
    valid = 1; dma = 1; addr = 32'h30; write = 0; wstrb = 8'hFF;
    neg(); chk("dma_conf0", 64'(conflict), 64'd1);
    chk("dma_ready0", 64'(ready), 64'd1);
    chk("dma_wen0", 64'(mem_wen), 64'd0);
    nxt();
    neg(); chk("dma_conf1", 64'(conflict), 64'd1);
    chk("dma_wen1", 64'(mem_wen), 64'd0);
    nxt(); idle();
    neg(); chk("dma_wb", 64'({mem_req, mem_wen}), 64'd3);
    chk("dma_wb_add", 64'(mem_add), 64'h30);
    chk("dma_wb_data", mem_wdata, 64'hAB);
    chk("dma_conf_off", 64'(conflict), 64'd0);
    nxt();
    neg(); chk("dma_after_ready", 64'(ready), 64'd1);
    chk("dma_mem", mem[8'h30], 64'hAB);
    nxt();

    // Reset during DoAMO drops the write-back
    drive(AMOAdd, 1, 32'h50, 0, 64'h1, 8'hFF, 3'd0, 1);
    neg(); nxt(); idle();
    rst_n = 0;
    neg();
    #1 rst_n = 1;
    neg();
    chk("rstamo_ready", 64'(ready), 64'd1);
    chk("rstamo_req", 64'(mem_req), 64'd0);
    nxt();
    neg(); chk("rstamo_ready2", 64'(ready), 64'd1);
    nxt();
    neg(); chk("rstamo_mem", mem[8'h50], 64'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
